// File: rtl/wdt_pkg.sv
// Shared types for the multi-channel watchdog supervisor.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_WAIT  = 2'b10,
        ST_ERROR = 2'b11
    } wdt_state_t;

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: arm on enable, count from the first kick, trip on a missed deadline.
module wdt_channel
    import wdt_pkg::*;
#(
    parameter int TW       = 16,
    parameter int WARN_CYC = 8,
    parameter bit STICKY   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          kick,
    input  logic          clr,
    input  logic [TW-1:0] timeout_val,
    output wdt_state_t    state,
    output logic          warn,
    output logic          err_entry
);

    localparam logic [TW-1:0] WARN_LIM = TW'(WARN_CYC);

    wdt_state_t    state_q, state_d;
    logic [TW-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // clr beats a dropped enable, which in turn never releases a latched error.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else if (!en && state_q != ST_ERROR) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (kick) begin
                        state_d = ST_RUN;
                        count_d = timeout_val;
                    end
                end
                ST_RUN: begin
                    if (kick) begin
                        count_d = timeout_val;
                    end else if (count_q == '0) begin
                        state_d = ST_ERROR;
                    end else begin
                        count_d = count_q - TW'(1);
                    end
                end
                ST_ERROR: begin
                    if (!STICKY) begin
                        state_d = en ? ST_WAIT : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign state     = state_q;
    assign warn      = (state_q == ST_RUN) && (count_q < WARN_LIM);
    assign err_entry = (state_q != ST_ERROR) && (state_d == ST_ERROR);

endmodule

// File: rtl/wdt_supervisor.sv
// Multi-channel watchdog supervisor: per-channel FSMs plus a shared saturating fault counter.
module wdt_supervisor
    import wdt_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int TW       = 16,
    parameter int WARN_CYC = 8,
    parameter bit STICKY   = 1'b1,
    parameter int FCW      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic [N_CH-1:0]   kick,
    input  logic [N_CH-1:0]   clr,
    input  logic [TW-1:0]     timeout_val,
    output logic [N_CH-1:0]   running,
    output logic [N_CH-1:0]   warn,
    output logic [N_CH-1:0]   error,
    output logic              any_error,
    output logic [FCW-1:0]    fault_cnt,
    output logic [2*N_CH-1:0] ch_state
);

    localparam int PCW = $clog2(N_CH + 1);
    localparam int SW  = ((FCW > PCW) ? FCW : PCW) + 1;

    logic [N_CH-1:0] err_entry;
    logic [PCW-1:0]  n_entries;
    logic [SW-1:0]   fault_sum;
    logic [FCW-1:0]  fault_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        wdt_state_t st;

        wdt_channel #(
            .TW       (TW),
            .WARN_CYC (WARN_CYC),
            .STICKY   (STICKY)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en[i]),
            .kick        (kick[i]),
            .clr         (clr[i]),
            .timeout_val (timeout_val),
            .state       (st),
            .warn        (warn[i]),
            .err_entry   (err_entry[i])
        );

        assign running[i]         = (st == ST_RUN);
        assign error[i]           = (st == ST_ERROR);
        assign ch_state[2*i +: 2] = st;
    end

    always_comb begin
        n_entries = '0;
        for (int i = 0; i < N_CH; i++) begin
            n_entries = n_entries + PCW'(err_entry[i]);
        end
    end

    // Several channels can trip on one edge, so add the whole popcount before saturating.
    assign fault_sum = SW'(fault_cnt) + SW'(n_entries);
    assign fault_d   = (fault_sum > SW'({FCW{1'b1}})) ? {FCW{1'b1}} : fault_sum[FCW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt <= '0;
        end else begin
            fault_cnt <= fault_d;
        end
    end

    assign any_error = |error;

endmodule

// File: tb/tb_wdt_supervisor.sv
// Bench: sticky and non-sticky supervisors driven in lockstep, checked against a deadline-based model.
module tb_wdt_supervisor;

    localparam int N   = 2;
    localparam int TW  = 8;
    localparam int WC  = 2;
    localparam int FCW = 4;
    localparam int IVW = 4 + 2 + 2 + 2 + 1 + 4;
    localparam int VW  = 2 * IVW;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  en, kick, clr;
    logic [TW-1:0] tv;

    logic [N-1:0]   run_s, warn_s, err_s, run_n, warn_n, err_n;
    logic           any_s, any_n;
    logic [FCW-1:0] fc_s, fc_n;
    logic [2*N-1:0] st_s, st_n;

    always #5 clk = ~clk;

    wdt_supervisor #(.N_CH(N), .TW(TW), .WARN_CYC(WC), .STICKY(1'b1), .FCW(FCW)) dut_s (
        .clk(clk), .rst(rst), .en(en), .kick(kick), .clr(clr), .timeout_val(tv),
        .running(run_s), .warn(warn_s), .error(err_s), .any_error(any_s),
        .fault_cnt(fc_s), .ch_state(st_s)
    );

    wdt_supervisor #(.N_CH(N), .TW(TW), .WARN_CYC(WC), .STICKY(1'b0), .FCW(FCW)) dut_n (
        .clk(clk), .rst(rst), .en(en), .kick(kick), .clr(clr), .timeout_val(tv),
        .running(run_n), .warn(warn_n), .error(err_n), .any_error(any_n),
        .fault_cnt(fc_n), .ch_state(st_n)
    );

    // Model: instance 0 is sticky, instance 1 is not. A running channel holds a
    // deadline (load) and a count of kick-free cycles since it was loaded.
    bit m_armed [2][N];
    bit m_live  [2][N];
    bit m_trip  [2][N];
    int m_load    [2][N];
    int m_elapsed [2][N];
    int m_faults  [2];

    logic [VW-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int n_cyc = 0;

    task automatic model_idle(input int m, input int c);
        m_armed[m][c] = 0;
        m_live[m][c]  = 0;
        m_trip[m][c]  = 0;
    endtask

    task automatic model_step(input bit r, input logic [N-1:0] e, input logic [N-1:0] k,
                              input logic [N-1:0] cl, input logic [TW-1:0] t);
        for (int m = 0; m < 2; m++) begin
            int entered = 0;
            for (int c = 0; c < N; c++) begin
                if (r) begin
                    model_idle(m, c);
                    m_load[m][c]    = 0;
                    m_elapsed[m][c] = 0;
                end else if (cl[c]) begin
                    model_idle(m, c);
                end else if (!e[c] && !m_trip[m][c]) begin
                    model_idle(m, c);
                end else if (m_trip[m][c]) begin
                    if (m != 0) begin
                        m_trip[m][c]  = 0;
                        m_armed[m][c] = e[c];
                    end
                end else if (m_live[m][c]) begin
                    if (k[c]) begin
                        m_load[m][c]    = int'(t);
                        m_elapsed[m][c] = 0;
                    end else if (m_elapsed[m][c] == m_load[m][c]) begin
                        m_live[m][c] = 0;
                        m_trip[m][c] = 1;
                        entered++;
                    end else begin
                        m_elapsed[m][c]++;
                    end
                end else if (m_armed[m][c]) begin
                    if (k[c]) begin
                        m_armed[m][c]   = 0;
                        m_live[m][c]    = 1;
                        m_load[m][c]    = int'(t);
                        m_elapsed[m][c] = 0;
                    end
                end else begin
                    m_armed[m][c] = 1;
                end
            end
            if (r) m_faults[m] = 0;
            else   m_faults[m] = (m_faults[m] + entered > 15) ? 15 : m_faults[m] + entered;
        end
    endtask

    function automatic logic [IVW-1:0] inst_vec(input int m);
        logic [2*N-1:0] st;
        logic [N-1:0]   run, wrn, err;
        st = '0; run = '0; wrn = '0; err = '0;
        for (int c = 0; c < N; c++) begin
            run[c] = m_live[m][c];
            wrn[c] = m_live[m][c] && ((m_load[m][c] - m_elapsed[m][c]) < WC);
            err[c] = m_trip[m][c];
            st[2*c +: 2] = m_live[m][c] ? 2'd1 : m_armed[m][c] ? 2'd2 : m_trip[m][c] ? 2'd3 : 2'd0;
        end
        return {st, run, wrn, err, |err, FCW'(m_faults[m])};
    endfunction

    task automatic cycle(input bit r, input logic [N-1:0] e, input logic [N-1:0] k,
                         input logic [N-1:0] cl, input logic [TW-1:0] t);
        rst = r; en = e; kick = k; clr = cl; tv = t;
        model_step(r, e, k, cl, t);
        exp_q.push_back({inst_vec(0), inst_vec(1)});
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n, input logic [N-1:0] e);
        for (int i = 0; i < n; i++) cycle(1'b0, e, 2'b00, 2'b00, 8'd5);
    endtask

    always @(negedge clk) begin
        logic [VW-1:0] got, exp;
        n_cyc++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {st_s, run_s, warn_s, err_s, any_s, fc_s, st_n, run_n, warn_n, err_n, any_n, fc_n};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got=%h exp=%h (st,run,warn,err,any,fc x sticky|nonsticky)",
                         n_cyc, got, exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset, then arm channel 0 only.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b00, 2'b00, 2'b00, 8'd5);
        quiet(3, 2'b01);
        // Single kick, then let it time out.
        cycle(1'b0, 2'b01, 2'b01, 2'b00, 8'd5);
        quiet(10, 2'b01);
        // Kick while in error, then clear.
        cycle(1'b0, 2'b01, 2'b01, 2'b00, 8'd5);
        quiet(2, 2'b01);
        cycle(1'b0, 2'b01, 2'b00, 2'b01, 8'd5);
        quiet(2, 2'b01);
        // Regular kicks every 4 cycles, then every 6 (kick lands on count==0).
        cycle(1'b0, 2'b01, 2'b01, 2'b00, 8'd5);
        for (int i = 0; i < 10; i++) begin
            quiet(3, 2'b01);
            cycle(1'b0, 2'b01, 2'b01, 2'b00, 8'd5);
        end
        for (int i = 0; i < 6; i++) begin
            quiet(5, 2'b01);
            cycle(1'b0, 2'b01, 2'b01, 2'b00, 8'd5);
        end
        quiet(1, 2'b00);
        // Both channels time out together, repeatedly, to saturate the fault counter.
        quiet(1, 2'b11);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 2'b11, 2'b11, 2'b00, 8'd5);
            quiet(7, 2'b11);
            cycle(1'b0, 2'b11, 2'b00, 2'b11, 8'd5);
            quiet(1, 2'b11);
        end
        // Reset in the middle of a count.
        cycle(1'b0, 2'b11, 2'b11, 2'b00, 8'd5);
        quiet(3, 2'b11);
        cycle(1'b1, 2'b11, 2'b00, 2'b00, 8'd5);
        quiet(2, 2'b11);
        // Randomized traffic, including timeout_val changes mid-count.
        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] e, k, cl;
            for (int c = 0; c < N; c++) begin
                e[c]  = ($urandom_range(0, 9) != 0);
                k[c]  = ($urandom_range(0, 3) == 0);
                cl[c] = ($urandom_range(0, 29) == 0);
            end
            cycle($urandom_range(0, 199) == 0, e, k, cl, TW'($urandom_range(0, 9)));
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wdt_supervisor.md
# wdt_supervisor

Multi-channel watchdog supervisor. Each of `N_CH` channels has its own state machine and down-counter. A channel arms on enable, starts counting on its first kick, and latches an error when no kick arrives within a programmable timeout. Per-channel running, warning and error flags and a saturating fault counter go to the status/display logic; `clr` inputs come from the manual-reset buttons.

## Interface
- `N_CH`, 4 — number of independent channels (1..16)
- `TW`, 16 — counter / timeout width in bits
- `WARN_CYC`, 8 — `warn` asserts while the remaining count < `WARN_CYC`
- `STICKY`, 1 — 1: ERROR held until `clr`; 0: ERROR lasts one cycle, then WAIT
- `FCW`, 8 — fault counter width
- `clk` in 1 — system clock
- `rst` in 1 — synchronous, active-high reset
- `en` in N_CH — per-channel enable (level)
- `kick` in N_CH — per-channel activity pulse (one cycle per event)
- `clr` in N_CH — per-channel manual clear (level or pulse)
- `timeout_val` in TW — shared reload value, sampled whenever a counter loads
- `running` out N_CH — channel in RUN
- `warn` out N_CH — channel in RUN with count < `WARN_CYC`
- `error` out N_CH — channel in ERROR
- `any_error` out 1 — OR of `error`
- `fault_cnt` out FCW — saturating count of ERROR entries

## Operation
- Per-channel states and encoding: IDLE=2'b00, RUN=2'b01, WAIT=2'b10, ERROR=2'b11.
- Transition priority per channel, highest first: `rst` > `clr` > `en`=0 > normal.
- `clr`=1 → IDLE from any state.
- `en`=0 → IDLE from IDLE, WAIT or RUN. It does not leave ERROR.
- IDLE → WAIT when `en`=1.
- WAIT → RUN on `kick`; count ← `timeout_val`.
- In RUN:
  - `kick`: count ← `timeout_val` (reload).
  - Else if count==0: → ERROR.
  - Else count ← count−1.
  - `kick` with count==0 in the same cycle: the reload wins and no error occurs.
- In ERROR:
  - `STICKY`=1: stay until `clr`.
  - `STICKY`=0: → WAIT next cycle (→ IDLE if `en`=0).
  - `kick` is ignored.
- Counter holds its value outside RUN. Arithmetic is unsigned TW-bit and never wraps below 0.
- `fault_cnt` += number of channels entering ERROR this cycle, saturating at 2^FCW−1. Only `rst` clears it.
- All per-channel outputs decode from the registered state and count. `any_error` is combinational OR of `error`.

## Timing
- Reset values: all states IDLE, counts 0, `running`/`warn`/`error`/`any_error`=0, `fault_cnt`=0.
- All state, count and `fault_cnt` updates take effect on the clock edge after the input is sampled.
- Timeout latency: last kick at edge k (count loaded with T) → `error`=1 after edge k+T+1, i.e. T+1 kick-free cycles. T=0 errors after one kick-free cycle.
- `warn` rises when count first drops below `WARN_CYC`. It falls the cycle after a reload, or on leaving RUN.
- `timeout_val` changes affect only subsequent loads, never a count in progress.
- `rst` asserted mid-count: everything returns to reset values on that edge, with no fault counted.

## Structure
- Package `wdt_pkg`: `wdt_state_t` enum (the four encodings above) and the state-name constants.
- Sub-module `wdt_channel`: one FSM plus one TW-bit counter, parameters TW, WARN_CYC, STICKY. Outputs the state, `warn`, and an `err_entry` pulse.
- Top `wdt_supervisor`: generate loop of `wdt_channel`, popcount of `err_entry`, saturating `fault_cnt`, `any_error` OR.

## Test plan
Configuration: N_CH=2, TW=8, WARN_CYC=2, STICKY=1, FCW=4, `timeout_val`=5 unless noted.
1. Release `rst`, `en`=2'b01:
   - ch0 in WAIT one cycle later.
   - ch1 stays IDLE.
   - All outputs 0.
2. Kick ch0 once, then no kicks:
   - `running[0]` for 6 cycles.
   - `warn[0]` while count ∈ {1,0}.
   - `error[0]`=1 and `any_error`=1 on the 7th edge.
   - `fault_cnt`=1.
3. Kick ch0 every 4 cycles for 40 cycles:
   - Never errors, never warns.
   - Kick coincident with count==0 (kick period 6) also never errors.
4. From ERROR:
   - Pulse `kick`: state unchanged.
   - Pulse `clr[0]`: IDLE next cycle, then WAIT.
   - `fault_cnt` unchanged.
5. Both channels time out on the same edge:
   - `fault_cnt` increments by 2.
   - Repeat to 15: `fault_cnt` saturates at 4'hF.
6. Mode and reset edge cases:
   - STICKY=0: ERROR lasts exactly one cycle, then WAIT.
   - `rst` asserted mid-count: all reset values on the next edge.
